// File: rtl/neuro_cfg_pkg.sv
// Shared definitions for the neuron configuration loader: opcode values,
// FSM state encoding, control-byte field positions and sizing helpers.
package neuro_cfg_pkg;

  // Packet opcodes (first byte of every packet)
  localparam logic [7:0] OP_SET_CTRL    = 8'h01;
  localparam logic [7:0] OP_ADDR_WEIGHT = 8'h02;
  localparam logic [7:0] OP_WEIGHT_NEXT = 8'h03;
  localparam logic [7:0] OP_END         = 8'hFF;

  // Parser states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ID    = 3'd1;
  localparam logic [2:0] ST_CTRL  = 3'd2;
  localparam logic [2:0] ST_ADDR  = 3'd3;
  localparam logic [2:0] ST_VALUE = 3'd4;

  // Control byte 0 layout; control byte 1 carries only the accumulator init bit
  localparam int unsigned DECAY_LSB       = 0;
  localparam int unsigned DECAY_W         = 3;
  localparam int unsigned ADDER_INIT_LSB  = 3;
  localparam int unsigned ADDER_INIT_W    = 3;
  localparam int unsigned ADDER_MODEL_LSB = 6;
  localparam int unsigned ADDER_MODEL_W   = 2;
  localparam int unsigned ACC_INIT_BIT    = 0;

  // Ceiling log2, minimum result 0 (clog2(1) == 0)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Integer ceiling division
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cfg_byte_assembler.sv
// Collects NUM_BYTES bytes little-endian (first byte lands in the LSBs).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            a byte for this field is accepted this cycle
//   data          the byte
//   done_c        high in the cycle the final byte is accepted
//   field_c       assembled field including the current byte (valid with done_c)
module cfg_byte_assembler
  import neuro_cfg_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 1,
  parameter int unsigned OUT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       data,
  output logic             done_c,
  output logic [OUT_W-1:0] field_c
);

  localparam int unsigned FW    = NUM_BYTES * 8;
  localparam int unsigned CNT_W = clog2(NUM_BYTES + 1);

  logic [FW-1:0]    sreg;
  logic [FW-1:0]    nxt;
  logic [CNT_W-1:0] cnt;

  // New byte enters at the top; after NUM_BYTES shifts the first byte is at the bottom
  assign nxt     = FW'({data, sreg} >> 8);
  assign field_c = nxt[OUT_W-1:0];
  assign done_c  = en && (cnt == CNT_W'(NUM_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (en) begin
      sreg <= nxt;
      cnt  <= done_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/neuron_cfg_loader.sv
// Byte-stream configuration decoder for the neuron array.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_data/in_ready  host byte stream (valid/ready)
//   ctrl_we, ctrl_id, decay_mode, init_mode_adder, adder_model, init_mode_acc
//                            per-neuron control write (one-cycle pulse)
//   wr_valid/wr_ready, wr_id, wr_addr, wr_value
//                            weight write port (valid/ready)
//   load                     one-cycle end-of-configuration pulse
//   neuron_mode              1 = configuring, 0 = running
//   err_opcode, err_range    sticky error flags
module neuron_cfg_loader
  import neuro_cfg_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned VALUE_W     = 32,
  localparam int unsigned ID_W       = clog2(NUM_NEURONS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               ctrl_we,
  output logic [ID_W-1:0]    ctrl_id,
  output logic [2:0]         decay_mode,
  output logic [2:0]         init_mode_adder,
  output logic [1:0]         adder_model,
  output logic               init_mode_acc,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ID_W-1:0]    wr_id,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [VALUE_W-1:0] wr_value,
  output logic               load,
  output logic               neuron_mode,
  output logic               err_opcode,
  output logic               err_range
);

  localparam int unsigned ID_BYTES   = ceil_div(ID_W, 8);
  localparam int unsigned ID_FW      = ID_BYTES * 8;
  localparam int unsigned CMP_W      = ID_FW + 1;
  localparam int unsigned ADDR_BYTES = ceil_div(ADDR_W, 8);
  localparam int unsigned VAL_BYTES  = ceil_div(VALUE_W, 8);

  logic [2:0]         state, state_nxt;
  logic [7:0]         op;
  logic               ctrl_phase;
  logic [7:0]         ctrl_byte0;
  logic [ID_W-1:0]    id_q;
  logic               id_bad;
  logic [ADDR_W-1:0]  auto_addr;

  logic               accept;
  logic               id_en, addr_en, val_en;
  logic               id_done_c, addr_done_c, val_done_c;
  logic [ID_FW-1:0]   id_field_c;
  logic [ADDR_W-1:0]  addr_field_c;
  logic [VALUE_W-1:0] val_field_c;
  logic               id_out_of_range;

  logic               op_start, op_bad, end_seen, ctrl_fire, wr_fire;

  // Combinational so a write accepted in its first cycle costs no input bubble
  assign in_ready = !(wr_valid && !wr_ready);
  assign accept   = in_valid && in_ready;
  assign id_en    = accept && (state == ST_ID);
  assign addr_en  = accept && (state == ST_ADDR);
  assign val_en   = accept && (state == ST_VALUE);

  // Full collected id is range-checked, not just the ID_W bits kept
  assign id_out_of_range = CMP_W'(id_field_c) >= CMP_W'(NUM_NEURONS);

  cfg_byte_assembler #(.NUM_BYTES(ID_BYTES), .OUT_W(ID_FW)) u_id_asm (
    .clk(clk), .rst(rst), .en(id_en), .data(in_data),
    .done_c(id_done_c), .field_c(id_field_c)
  );

  cfg_byte_assembler #(.NUM_BYTES(ADDR_BYTES), .OUT_W(ADDR_W)) u_addr_asm (
    .clk(clk), .rst(rst), .en(addr_en), .data(in_data),
    .done_c(addr_done_c), .field_c(addr_field_c)
  );

  cfg_byte_assembler #(.NUM_BYTES(VAL_BYTES), .OUT_W(VALUE_W)) u_val_asm (
    .clk(clk), .rst(rst), .en(val_en), .data(in_data),
    .done_c(val_done_c), .field_c(val_field_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle decode strobes
  always_comb begin
    state_nxt = state;
    op_start  = 1'b0;
    op_bad    = 1'b0;
    end_seen  = 1'b0;
    ctrl_fire = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_data == OP_SET_CTRL || in_data == OP_ADDR_WEIGHT ||
              in_data == OP_WEIGHT_NEXT) begin
            op_start  = 1'b1;
            state_nxt = ST_ID;
          end else if (in_data == OP_END) begin
            end_seen = 1'b1;
          end else begin
            op_bad = 1'b1;
          end
        end
      end
      ST_ID: begin
        if (id_done_c) begin
          if (op == OP_SET_CTRL)         state_nxt = ST_CTRL;
          else if (op == OP_ADDR_WEIGHT) state_nxt = ST_ADDR;
          else                           state_nxt = ST_VALUE;
        end
      end
      ST_CTRL: begin
        if (accept && ctrl_phase) begin
          ctrl_fire = !id_bad;
          state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (addr_done_c) state_nxt = ST_VALUE;
      end
      ST_VALUE: begin
        if (val_done_c) begin
          wr_fire   = !id_bad;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op              <= '0;
      ctrl_phase      <= 1'b0;
      ctrl_byte0      <= '0;
      id_q            <= '0;
      id_bad          <= 1'b0;
      auto_addr       <= '0;
      ctrl_we         <= 1'b0;
      ctrl_id         <= '0;
      decay_mode      <= '0;
      init_mode_adder <= '0;
      adder_model     <= '0;
      init_mode_acc   <= 1'b0;
      wr_valid        <= 1'b0;
      wr_id           <= '0;
      wr_addr         <= '0;
      wr_value        <= '0;
      load            <= 1'b0;
      neuron_mode     <= 1'b1;
      err_opcode      <= 1'b0;
      err_range       <= 1'b0;
    end else begin
      ctrl_we <= ctrl_fire;
      load    <= end_seen;

      if (op_start) begin
        op          <= in_data;
        neuron_mode <= 1'b1;
      end
      if (end_seen) neuron_mode <= 1'b0;
      if (op_bad)   err_opcode  <= 1'b1;

      if (id_done_c) begin
        id_q   <= id_field_c[ID_W-1:0];
        id_bad <= id_out_of_range;
        if (id_out_of_range) err_range <= 1'b1;
      end

      // Two control bytes: hold the first, apply both on the second
      if (accept && state == ST_CTRL) begin
        ctrl_phase <= !ctrl_phase;
        if (!ctrl_phase) ctrl_byte0 <= in_data;
      end
      if (ctrl_fire) begin
        ctrl_id         <= id_q;
        decay_mode      <= ctrl_byte0[DECAY_LSB +: DECAY_W];
        init_mode_adder <= ctrl_byte0[ADDER_INIT_LSB +: ADDER_INIT_W];
        adder_model     <= ctrl_byte0[ADDER_MODEL_LSB +: ADDER_MODEL_W];
        init_mode_acc   <= in_data[ACC_INIT_BIT];
      end

      // Completed transfer advances the auto-address; an ADDR field overrides it
      if (wr_valid && wr_ready) begin
        wr_valid  <= 1'b0;
        auto_addr <= auto_addr + ADDR_W'(1);
      end
      if (addr_done_c) auto_addr <= addr_field_c;

      if (wr_fire) begin
        wr_valid <= 1'b1;
        wr_id    <= id_q;
        wr_addr  <= auto_addr;
        wr_value <= val_field_c;
      end
    end
  end

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Self-checking bench for neuron_cfg_loader: a packet-level model predicts
// every output each cycle, plus literal checks on decoded transactions.
module tb_neuron_cfg_loader;

  localparam int NUM = 32;
  localparam int AW  = 10;
  localparam int VW  = 32;
  localparam int IDW = 5;
  localparam int IDB = 1;
  localparam int AB  = 2;
  localparam int VB  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           ctrl_we;
  logic [IDW-1:0] ctrl_id;
  logic [2:0]     decay_mode;
  logic [2:0]     init_mode_adder;
  logic [1:0]     adder_model;
  logic           init_mode_acc;
  logic           wr_valid;
  logic           wr_ready;
  logic [IDW-1:0] wr_id;
  logic [AW-1:0]  wr_addr;
  logic [VW-1:0]  wr_value;
  logic           load;
  logic           neuron_mode;
  logic           err_opcode;
  logic           err_range;

  always #5 clk = ~clk;

  neuron_cfg_loader #(.NUM_NEURONS(NUM), .ADDR_W(AW), .VALUE_W(VW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ctrl_we(ctrl_we), .ctrl_id(ctrl_id), .decay_mode(decay_mode),
    .init_mode_adder(init_mode_adder), .adder_model(adder_model),
    .init_mode_acc(init_mode_acc),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id),
    .wr_addr(wr_addr), .wr_value(wr_value),
    .load(load), .neuron_mode(neuron_mode),
    .err_opcode(err_opcode), .err_range(err_range)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  logic [7:0] pkt[$];
  logic   e_ctrl_we, e_load, e_mode, e_err_op, e_err_rng, e_wr_valid;
  longint e_ctrl_id, e_decay, e_iadd, e_am, e_acc;
  longint e_wr_id, e_wr_addr, e_wr_value, m_addr;
  logic   mon_en = 1'b0;

  function automatic longint le(input int start, input int n);
    longint v;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(pkt[start + i]) << (8 * i));
    return v;
  endfunction

  task automatic model_reset();
    pkt.delete();
    e_ctrl_we = 1'b0; e_load = 1'b0; e_mode = 1'b1;
    e_err_op = 1'b0; e_err_rng = 1'b0; e_wr_valid = 1'b0;
    e_ctrl_id = 0; e_decay = 0; e_iadd = 0; e_am = 0; e_acc = 0;
    e_wr_id = 0; e_wr_addr = 0; e_wr_value = 0; m_addr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int     need;
    longint id, val;
    pkt.push_back(b);
    if (pkt.size() == 1) begin
      if (b == 8'h01 || b == 8'h02 || b == 8'h03) begin
        e_mode = 1'b1;
      end else begin
        if (b == 8'hFF) begin
          e_load = 1'b1;
          e_mode = 1'b0;
        end else begin
          e_err_op = 1'b1;
        end
        pkt.delete();
      end
    end else begin
      if (pkt[0] == 8'h01)      need = 1 + IDB + 2;
      else if (pkt[0] == 8'h02) need = 1 + IDB + AB + VB;
      else                      need = 1 + IDB + VB;
      id = le(1, IDB);
      if (pkt.size() == 1 + IDB && id >= longint'(NUM)) e_err_rng = 1'b1;
      if (pkt.size() == need) begin
        if (pkt[0] == 8'h01) begin
          if (id < longint'(NUM)) begin
            e_ctrl_we = 1'b1;
            e_ctrl_id = id;
            e_decay   = longint'(pkt[1 + IDB]) % 8;
            e_iadd    = (longint'(pkt[1 + IDB]) / 8) % 8;
            e_am      = longint'(pkt[1 + IDB]) / 64;
            e_acc     = longint'(pkt[2 + IDB]) % 2;
          end
        end else begin
          if (pkt[0] == 8'h02) begin
            m_addr = le(1 + IDB, AB) % (longint'(1) << AW);
            val    = le(1 + IDB + AB, VB);
          end else begin
            val = le(1 + IDB, VB);
          end
          if (id < longint'(NUM)) begin
            e_wr_valid = 1'b1;
            e_wr_id    = id;
            e_wr_addr  = m_addr;
            e_wr_value = val % (longint'(1) << VW);
          end
        end
        pkt.delete();
      end
    end
  endtask

  // Advance model across the coming clock edge using the inputs now stable
  task automatic model_advance();
    logic acc;
    if (rst) begin
      model_reset();
    end else begin
      acc = in_valid && !(e_wr_valid && !wr_ready);
      e_ctrl_we = 1'b0;
      e_load    = 1'b0;
      if (e_wr_valid && wr_ready) begin
        e_wr_valid = 1'b0;
        m_addr = (m_addr + 1) % (longint'(1) << AW);
      end
      if (acc) model_byte(in_data);
    end
  endtask

  // ---------------- monitor / compare ----------------
  int n_ctrl = 0, n_wr = 0, n_load = 0, n_stall = 0;
  longint cap_ctrl_id, cap_decay, cap_iadd, cap_am, cap_acc;
  longint cap_wr_id, cap_wr_addr, cap_wr_value;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, !(e_wr_valid && !wr_ready));
      chk("ctrl_we", ctrl_we, e_ctrl_we);
      chk("ctrl_id", ctrl_id, e_ctrl_id);
      chk("decay_mode", decay_mode, e_decay);
      chk("init_mode_adder", init_mode_adder, e_iadd);
      chk("adder_model", adder_model, e_am);
      chk("init_mode_acc", init_mode_acc, e_acc);
      chk("wr_valid", wr_valid, e_wr_valid);
      if (e_wr_valid) begin
        chk("wr_id", wr_id, e_wr_id);
        chk("wr_addr", wr_addr, e_wr_addr);
        chk("wr_value", wr_value, e_wr_value);
      end
      chk("load", load, e_load);
      chk("neuron_mode", neuron_mode, e_mode);
      chk("err_opcode", err_opcode, e_err_op);
      chk("err_range", err_range, e_err_rng);

      if (ctrl_we) begin
        n_ctrl++;
        cap_ctrl_id = ctrl_id; cap_decay = decay_mode; cap_iadd = init_mode_adder;
        cap_am = adder_model; cap_acc = init_mode_acc;
      end
      if (wr_valid && wr_ready) begin
        n_wr++;
        cap_wr_id = wr_id; cap_wr_addr = wr_addr; cap_wr_value = wr_value;
      end
      if (load) n_load++;
      if (in_valid && !in_ready) n_stall++;
    end
    model_advance();
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bytes: first byte in the most significant occupied position
  task automatic send(input logic [127:0] bytes, input int n);
    logic acc;
    int   cyc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[8 * (n - 1 - i) +: 8];
      cyc = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end while (!acc && cyc < 64);
      if (!acc) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d not accepted, got in_ready=0 expected 1", i);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ctrl, b_wr, b_load, b_stall;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_neuron_mode", neuron_mode, 1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_err_opcode", err_opcode, 0);

    // 1: control write
    b_ctrl = n_ctrl;
    send(128'({8'h01, 8'h00, 8'hC5, 8'h01}), 4);
    idle(3);
    chk("t1_ctrl_count", 64'(n_ctrl - b_ctrl), 1);
    chk("t1_ctrl_id", cap_ctrl_id, 0);
    chk("t1_decay", cap_decay, 5);
    chk("t1_iadd", cap_iadd, 0);
    chk("t1_am", cap_am, 3);
    chk("t1_acc", cap_acc, 1);

    // 2: addressed write then auto-increment with wrap
    b_wr = n_wr;
    send(128'({8'h02, 8'h03, 8'hFF, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12}), 8);
    idle(3);
    chk("t2_wr_count", 64'(n_wr - b_wr), 1);
    chk("t2_wr_id", cap_wr_id, 3);
    chk("t2_wr_addr", cap_wr_addr, 64'h3FF);
    chk("t2_wr_value", cap_wr_value, 64'h12345678);
    send(128'({8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}), 6);
    idle(3);
    chk("t2_next_addr", cap_wr_addr, 0);
    chk("t2_next_value", cap_wr_value, 1);

    // 3: backpressure for 5 cycles with a following packet queued
    b_wr = n_wr; b_stall = n_stall;
    wr_ready = 1'b0;
    fork
      send(128'({8'h02, 8'h03, 8'hFF, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'h03, 8'h04, 8'hAA, 8'h00, 8'h00, 8'h00}), 14);
      begin
        int k;
        k = 0;
        while (k < 200) begin
          @(negedge clk);
          if (wr_valid) break;
          k++;
        end
        if (k >= 200) begin
          n_tests++;
          n_fail++;
          $display("FAIL t3_wait_wr_valid: got 0 expected 1");
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join
    idle(3);
    chk("t3_stall_cycles", 64'(n_stall - b_stall), 5);
    chk("t3_wr_count", 64'(n_wr - b_wr), 2);
    chk("t3_next_id", cap_wr_id, 4);
    chk("t3_next_addr", cap_wr_addr, 0);
    chk("t3_next_value", cap_wr_value, 64'hAA);

    // 4: unknown opcode, then a valid packet
    b_ctrl = n_ctrl; b_wr = n_wr; b_load = n_load;
    send(128'(8'h7E), 1);
    idle(2);
    chk("t4_err_opcode", err_opcode, 1);
    chk("t4_err_range", err_range, 0);
    chk("t4_no_activity", 64'((n_ctrl - b_ctrl) + (n_wr - b_wr) + (n_load - b_load)), 0);
    send(128'({8'h01, 8'h02, 8'h0A, 8'h00}), 4);
    idle(3);
    chk("t4_ctrl_id", cap_ctrl_id, 2);
    chk("t4_decay", cap_decay, 2);
    chk("t4_iadd", cap_iadd, 1);
    chk("t4_am", cap_am, 0);

    // 5: out-of-range id, then END
    b_ctrl = n_ctrl; b_load = n_load;
    send(128'({8'h01, 8'h28, 8'h00, 8'h00}), 4);
    idle(2);
    chk("t5_err_range", err_range, 1);
    chk("t5_no_ctrl", 64'(n_ctrl - b_ctrl), 0);
    send(128'(8'hFF), 1);
    idle(3);
    chk("t5_load_count", 64'(n_load - b_load), 1);
    chk("t5_neuron_mode", neuron_mode, 0);

    // 6: reset mid-packet, then a fresh packet
    send(128'({8'h02, 8'h05, 8'h10}), 3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("t6_err_range", err_range, 0);
    chk("t6_err_opcode", err_opcode, 0);
    chk("t6_neuron_mode", neuron_mode, 1);
    chk("t6_ctrl_id", ctrl_id, 0);
    b_ctrl = n_ctrl;
    send(128'({8'h01, 8'h01, 8'h00, 8'h00}), 4);
    idle(3);
    chk("t6_ctrl_count", 64'(n_ctrl - b_ctrl), 1);
    chk("t6_ctrl_id_after", cap_ctrl_id, 1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_cfg_loader.md
Name: neuron_cfg_loader

Overview:
Byte-stream configuration decoder for the neuron array, parametrised in neuron count, weight-address width and weight-value width. It parses opcode packets from the host link with a valid/ready handshake. It drives per-neuron control fields, a weight-write port with its own valid/ready handshake, and an end-of-configuration load pulse. It sits between the host/UART byte bridge and the neuron cluster, and adds range checking, sticky error flags and address auto-increment.

Parameters:
NUM_NEURONS, 32, number of addressable neurons (>=2); ID_W = clog2(NUM_NEURONS), ID_BYTES = ceil(ID_W/8)
ADDR_W, 10, weight address width (1..32); ADDR_BYTES = ceil(ADDR_W/8)
VALUE_W, 32, weight value width (8..32); VAL_BYTES = ceil(VALUE_W/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  byte available
in_data  in  8  packet byte
in_ready  out  1  byte accepted when in_valid&&in_ready
ctrl_we  out  1  one-cycle pulse: control fields valid for ctrl_id
ctrl_id  out  ID_W  target neuron of control write
decay_mode  out  3  control field
init_mode_adder  out  3  control field
adder_model  out  2  control field
init_mode_acc  out  1  control field
wr_valid  out  1  weight write pending
wr_ready  in  1  weight sink accepts
wr_id  out  ID_W  target neuron
wr_addr  out  ADDR_W  weight address
wr_value  out  VALUE_W  weight value
load  out  1  one-cycle end-of-config pulse
neuron_mode  out  1  1 = configuring, 0 = running
err_opcode  out  1  sticky: unknown opcode seen
err_range  out  1  sticky: neuron id >= NUM_NEURONS

Behaviour:
- Reset: all outputs 0 except neuron_mode=1 and in_ready=1; FSM to IDLE; byte counter 0; auto-address register 0.
- Opcodes: SET_CTRL=0x01, ADDR_WEIGHT=0x02, WEIGHT_NEXT=0x03, END=0xFF. Multi-byte fields are little-endian; unused upper bits are ignored.
- FSM states: IDLE, ID, CTRL, ADDR, VALUE.
- IDLE, opcode byte:
  - 0x01/0x02/0x03 -> ID, and neuron_mode<=1.
  - 0xFF -> load=1 for exactly one cycle (the cycle after acceptance), neuron_mode<=0, stay IDLE.
  - Any other byte -> err_opcode<=1, stay IDLE.
- ID: collect ID_BYTES bytes.
  - SET_CTRL -> CTRL.
  - ADDR_WEIGHT -> ADDR.
  - WEIGHT_NEXT -> VALUE.
- CTRL: collect 2 bytes. Byte0 [2:0]=decay_mode, [5:3]=init_mode_adder, [7:6]=adder_model. Byte1 bit0=init_mode_acc.
  - After the second byte: fields update and ctrl_we pulses the next cycle, then -> IDLE.
- ADDR: collect ADDR_BYTES bytes into the auto-address register, then -> VALUE.
- VALUE: collect VAL_BYTES bytes.
  - After the last byte: wr_valid<=1 with wr_id/wr_addr=auto-address/wr_value, then -> IDLE.
  - The auto-address increments by 1 (mod 2^ADDR_W, wraps) on each wr_valid&&wr_ready.
  - WEIGHT_NEXT therefore writes to the previous address +1.
- Weight handshake: wr_valid and payload stay stable until wr_ready.
  - in_ready=0 while wr_valid&&!wr_ready.
  - If wr_ready is already high in the first wr_valid cycle, the transfer completes in that cycle.
- Range error: a completed ID >= NUM_NEURONS sets err_range.
  - The packet is still consumed in full, but its ctrl_we/wr_valid is suppressed. The auto-address still updates from ADDR bytes.
- Sticky errors clear only on rst.
- Throughput: one byte per cycle when in_valid is held high. No bytes are dropped.
- Reset mid-packet: the partial packet is discarded and the reset values above apply, including dropping a pending wr_valid.
- neuron_mode returns to 1 on any valid non-END opcode after END.

Decomposition:
- Shared package neuro_cfg_pkg: opcode constants, FSM state encoding, control-byte bit-field positions, and a clog2/ceil-div helper function.
- One natural sub-module, cfg_byte_assembler: shift-collects N bytes little-endian with a counter and a done pulse. It is reused for the ID, ADDR and VALUE fields.

Test Plan:
1. After reset: 01 00 C5 01 -> ctrl_we pulse with ctrl_id=0, decay_mode=5, init_mode_adder=0, adder_model=3, init_mode_acc=1.
2. 02 03 FF 03 78 56 34 12 with wr_ready=1 -> single wr_valid with wr_id=3, wr_addr=0x3FF, wr_value=0x12345678. Then 03 03 01 00 00 00 -> wr_addr=0x000 (wrap), wr_value=1.
3. The same ADDR_WEIGHT packet with wr_ready held low for 5 cycles and in_valid continuously high -> in_ready low for those cycles, wr payload stable, no byte lost, the following packet decodes correctly.
4. Byte 0x7E in IDLE -> err_opcode=1, no other output activity. The next valid packet still decodes.
5. 01 28 00 00 (id 40 >= 32) -> err_range=1, no ctrl_we. FF -> load high exactly one cycle, neuron_mode=0.
6. rst asserted after 02 05 10 -> all outputs at reset values. A fresh 01 01 00 00 then decodes normally with ctrl_id=1.
